// File: rtl/exec_addx_seq.sv
// Segmented multi-cycle ADD/SUB/ADC/SBB: one W_SEG-bit slice per cycle with a
// registered ripple carry, valid/ready on both sides, {V,S,Z,C} flags.
`timescale 1ns/1ps
module exec_addx_seq #(
  parameter int W_OPR   = 64,
  parameter int W_SEG   = 16,
  parameter int W_FLAGS = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [W_OPR-1:0]   opr0_i,
  input  logic [W_OPR-1:0]   opr1_i,
  input  logic [1:0]         select_i,
  input  logic [W_FLAGS-1:0] flags_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [W_OPR-1:0]   result_o,
  output logic [W_FLAGS-1:0] flags_o
);

  localparam int NSEG  = W_OPR / W_SEG;
  localparam int W_CNT = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [W_CNT-1:0] LAST_SEG = W_CNT'(NSEG - 1);

  generate
    if (W_OPR % W_SEG != 0) begin : g_bad_seg
      $error("exec_addx_seq: W_OPR must be a multiple of W_SEG");
    end
    if (W_FLAGS < 4) begin : g_bad_flags
      $error("exec_addx_seq: W_FLAGS must hold {V,S,Z,C}");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [W_CNT-1:0]   cnt_reg;
  logic               carry_reg;
  logic               zacc_reg;
  logic               sel0_reg;
  logic               b_msb_reg;
  logic [W_OPR-1:0]   a_reg;
  logic [W_OPR-1:0]   b_reg;
  logic [W_OPR-1:0]   result_reg;
  logic [W_FLAGS-1:0] flags_reg;
  logic               valid_reg;

  logic [W_SEG-1:0]   seg_a;
  logic [W_SEG-1:0]   seg_b;
  logic [W_SEG-1:0]   seg_sum;
  logic               seg_carry;
  logic               zacc_next;
  logic [W_FLAGS-1:0] flags_next;

  // Only the carry bit of the incoming flags takes part in the arithmetic.
  logic unused_flags;
  assign unused_flags = ^flags_i[W_FLAGS-1:1];

  assign seg_a = a_reg[cnt_reg*W_SEG +: W_SEG];
  assign seg_b = b_reg[cnt_reg*W_SEG +: W_SEG];
  assign {seg_carry, seg_sum} = {1'b0, seg_a} + {1'b0, seg_b} + {{W_SEG{1'b0}}, carry_reg};
  assign zacc_next = zacc_reg & (seg_sum == '0);

  // Overflow uses the original operand B sign; b_reg already holds ~B for SUB/SBB.
  always_comb begin
    flags_next    = '0;
    flags_next[0] = seg_carry;
    flags_next[1] = zacc_next;
    flags_next[2] = seg_sum[W_SEG-1];
    flags_next[3] = ~(a_reg[W_OPR-1] ^ b_msb_reg ^ sel0_reg)
                    & (a_reg[W_OPR-1] ^ seg_sum[W_SEG-1]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      zacc_reg   <= 1'b0;
      sel0_reg   <= 1'b0;
      b_msb_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      valid_reg  <= 1'b0;
    end else if (flush_i) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            a_reg     <= opr0_i;
            b_reg     <= select_i[0] ? ~opr1_i : opr1_i;
            sel0_reg  <= select_i[0];
            b_msb_reg <= opr1_i[W_OPR-1];
            carry_reg <= select_i[0] ^ (flags_i[0] & select_i[1]);
            zacc_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          result_reg[cnt_reg*W_SEG +: W_SEG] <= seg_sum;
          carry_reg <= seg_carry;
          zacc_reg  <= zacc_next;
          if (cnt_reg == LAST_SEG) begin
            flags_reg <= flags_next;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready_o  = (state_reg == IDLE);
  assign valid_o  = valid_reg;
  assign result_o = result_reg;
  assign flags_o  = flags_reg;

endmodule

// File: tb/tb_exec_addx_seq.sv
// Directed bench for exec_addx_seq: 64/16 instance for most scenarios plus a
// 64/64 single-slice instance for the NSEG=1 latency case.
`timescale 1ns/1ps
module tb_exec_addx_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_i, flush;
  logic [63:0] opr0, opr1;
  logic [1:0]  sel;
  logic [3:0]  flags_in;
  logic        ready_o, valid_o;
  logic [63:0] result_o;
  logic [3:0]  flags_o;

  logic        v1, r1, fl1;
  logic [63:0] a1, b1;
  logic [1:0]  s1;
  logic [3:0]  f1;
  logic        rdy1, vo1;
  logic [63:0] res1;
  logic [3:0]  flg1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exec_addx_seq #(.W_OPR(64), .W_SEG(16), .W_FLAGS(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .opr0_i(opr0), .opr1_i(opr1), .select_i(sel), .flags_i(flags_in),
    .flush_i(flush), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .flags_o(flags_o)
  );

  exec_addx_seq #(.W_OPR(64), .W_SEG(64), .W_FLAGS(4)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(v1), .ready_o(rdy1),
    .opr0_i(a1), .opr1_i(b1), .select_i(s1), .flags_i(f1),
    .flush_i(fl1), .valid_o(vo1), .ready_i(r1),
    .result_o(res1), .flags_o(flg1)
  );

  // Issue one request on dut at a negedge and wait (bounded) for valid_o.
  // lat counts negedges after the acceptance edge; rdy_bad flags ready_o seen high meanwhile.
  task automatic do_op(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] f, output int lat, output bit rdy_bad);
    rdy_bad = 1'b0;
    sel = s; opr0 = a; opr1 = b; flags_in = f; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 20) begin
      if (ready_o) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (ready_o) rdy_bad = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake: ready_o=%b valid_o=%b required ready_o=1 valid_o=0", ready_o, valid_o);
    end
    tests++;
    if (result_o !== 64'h0 || flags_o !== 4'h0) begin
      fails++;
      $display("FAIL reset_outputs: result=%h flags=%b required 0/0000", result_o, flags_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_add();
    int lat; bit rb;
    do_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'h0, lat, rb);
    $display("[TB] ADD ffffffffffffffff+1 -> %h flags %b lat %0d", result_o, flags_o, lat);
    tests++;
    if (result_o !== 64'h0) begin
      fails++; $display("FAIL add_result: got %h required %h", result_o, 64'h0);
    end
    tests++;
    if (flags_o !== 4'b0011) begin
      fails++; $display("FAIL add_flags: got %b required 0011", flags_o);
    end
    tests++;
    if (lat !== 4) begin
      fails++; $display("FAIL add_latency: got %0d required 4", lat);
    end
    tests++;
    if (rb !== 1'b0) begin
      fails++; $display("FAIL add_ready_low: ready_o was 1 during BUSY/DONE, required 0");
    end
    @(negedge clk);
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++; $display("FAIL add_exit: ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_sub();
    int lat; bit rb;
    do_op(2'b01, 64'h8000_0000_0000_0000, 64'h1, 4'h0, lat, rb);
    $display("[TB] SUB 8000000000000000-1 -> %h flags %b", result_o, flags_o);
    tests++;
    if (result_o !== 64'h7FFF_FFFF_FFFF_FFFF || flags_o !== 4'b1001) begin
      fails++; $display("FAIL sub_overflow: got %h/%b required 7fffffffffffffff/1001", result_o, flags_o);
    end
    @(negedge clk);
    do_op(2'b01, 64'd5, 64'd5, 4'h0, lat, rb);
    $display("[TB] SUB 5-5 -> %h flags %b", result_o, flags_o);
    tests++;
    if (result_o !== 64'h0 || flags_o !== 4'b0011) begin
      fails++; $display("FAIL sub_zero: got %h/%b required 0/0011", result_o, flags_o);
    end
    @(negedge clk);
  endtask

  task automatic test_carry_ops();
    int lat; bit rb;
    do_op(2'b10, 64'd5, 64'd7, 4'b0001, lat, rb);
    $display("[TB] ADC 5+7+C1 -> %h flags %b", result_o, flags_o);
    tests++;
    if (result_o !== 64'd13 || flags_o !== 4'b0000) begin
      fails++; $display("FAIL adc: got %h/%b required d/0000", result_o, flags_o);
    end
    @(negedge clk);
    do_op(2'b11, 64'd5, 64'd3, 4'b0001, lat, rb);
    $display("[TB] SBB 5-3 C1 -> %h flags %b", result_o, flags_o);
    tests++;
    if (result_o !== 64'd1 || flags_o !== 4'b0001) begin
      fails++; $display("FAIL sbb_c1: got %h/%b required 1/0001", result_o, flags_o);
    end
    @(negedge clk);
    do_op(2'b11, 64'd5, 64'd3, 4'b0000, lat, rb);
    $display("[TB] SBB 5-3 C0 -> %h flags %b", result_o, flags_o);
    tests++;
    if (result_o !== 64'd2 || flags_o !== 4'b0001) begin
      fails++; $display("FAIL sbb_c0: got %h/%b required 2/0001", result_o, flags_o);
    end
    @(negedge clk);
  endtask

  task automatic test_cross_slice();
    int lat; bit rb;
    do_op(2'b00, 64'h0000_0000_0000_FFFF, 64'h1, 4'h0, lat, rb);
    $display("[TB] ADD ffff+1 -> %h flags %b", result_o, flags_o);
    tests++;
    if (result_o !== 64'h0000_0000_0001_0000 || flags_o !== 4'b0000) begin
      fails++; $display("FAIL cross_carry: got %h/%b required 10000/0000", result_o, flags_o);
    end
    @(negedge clk);
    do_op(2'b00, 64'h0001_0000_0000_0000, 64'hFFFF_0000_0000_0000, 4'h0, lat, rb);
    $display("[TB] ADD 0001<<48 + ffff<<48 -> %h flags %b", result_o, flags_o);
    tests++;
    if (result_o !== 64'h0 || flags_o !== 4'b0011) begin
      fails++; $display("FAIL cross_zero: got %h/%b required 0/0011", result_o, flags_o);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat; bit rb; bit unstable;
    ready_i = 1'b0;
    do_op(2'b00, 64'd3, 64'd4, 4'h0, lat, rb);
    tests++;
    if (result_o !== 64'd7 || lat !== 4) begin
      fails++; $display("FAIL bp_result: got %h lat %0d required 7 lat 4", result_o, lat);
    end
    sel = 2'b00; opr0 = 64'd100; opr1 = 64'd1; valid_i = 1'b1;
    unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid_o !== 1'b1 || result_o !== 64'd7 || flags_o !== 4'h0 || ready_o !== 1'b0)
        unstable = 1'b1;
    end
    $display("[TB] backpressure held 5 cycles result %h valid %b ready %b", result_o, valid_o, ready_o);
    tests++;
    if (unstable !== 1'b0) begin
      fails++; $display("FAIL bp_hold: outputs changed while ready_i=0, required stable");
    end
    ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    tests++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++; $display("FAIL bp_exit: valid_o=%b ready_o=%b required 0/1 (no early accept)", valid_o, ready_o);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int lat; bit rb; bit pulsed;
    sel = 2'b00; opr0 = 64'hFFFF_FFFF_FFFF_FFFF; opr1 = 64'h1; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    valid_i = 1'b0;
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++; $display("FAIL flush_idle: ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
    end
    pulsed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_o !== 1'b0) pulsed = 1'b1;
    end
    tests++;
    if (pulsed !== 1'b0) begin
      fails++; $display("FAIL flush_no_pulse: valid_o pulsed after flush, required none");
    end
    do_op(2'b00, 64'h1234, 64'h1111, 4'h0, lat, rb);
    $display("[TB] after flush ADD 1234+1111 -> %h flags %b", result_o, flags_o);
    tests++;
    if (result_o !== 64'h2345 || flags_o !== 4'b0000 || lat !== 4) begin
      fails++; $display("FAIL flush_next_op: got %h/%b lat %0d required 2345/0000 lat 4", result_o, flags_o, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int lat; bit rb;
    sel = 2'b00; opr0 = 64'h1111_1111_1111_1111; opr1 = 64'h1111_1111_1111_1111; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-BUSY result %h valid %b ready %b", result_o, valid_o, ready_o);
    tests++;
    if (result_o !== 64'h0 || flags_o !== 4'h0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++; $display("FAIL async_reset: result=%h flags=%b valid=%b ready=%b required 0/0000/0/1",
                        result_o, flags_o, valid_o, ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++; $display("FAIL async_release: ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
    end
    do_op(2'b00, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 4'h0, lat, rb);
    tests++;
    if (result_o !== 64'h2222_2222_2222_2222 || flags_o !== 4'b0000) begin
      fails++; $display("FAIL async_next_op: got %h/%b required 2222222222222222/0000", result_o, flags_o);
    end
    @(negedge clk);
  endtask

  task automatic test_single_slice();
    int lat;
    s1 = 2'b00; a1 = 64'hFFFF_FFFF_FFFF_FFFF; b1 = 64'h1; f1 = 4'h0; r1 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    lat = 0;
    while (!vo1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("[TB] NSEG=1 ADD -> %h flags %b lat %0d", res1, flg1, lat);
    tests++;
    if (res1 !== 64'h0 || flg1 !== 4'b0011) begin
      fails++; $display("FAIL single_result: got %h/%b required 0/0011", res1, flg1);
    end
    tests++;
    if (lat !== 1) begin
      fails++; $display("FAIL single_latency: got %0d required 1", lat);
    end
    @(negedge clk);
    tests++;
    if (rdy1 !== 1'b1 || vo1 !== 1'b0) begin
      fails++; $display("FAIL single_exit: ready=%b valid=%b required 1/0", rdy1, vo1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid_i = 1'b0; ready_i = 1'b1; flush = 1'b0;
    opr0 = '0; opr1 = '0; sel = '0; flags_in = '0;
    v1 = 1'b0; r1 = 1'b1; fl1 = 1'b0; a1 = '0; b1 = '0; s1 = '0; f1 = '0;
    test_reset();
    test_add();
    test_sub();
    test_carry_ops();
    test_cross_slice();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_single_slice();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_addx_seq.md
Name: exec_addx_seq

Overview:
Segmented, multi-cycle add/subtract unit for wide operands. It computes W_OPR-bit ADD/SUB/ADC/SBB one W_SEG-bit slice per cycle, rippling the carry through a register between slices. It produces the same {overflow, sign, zero, carry} flags as the single-cycle exec adder. It sits in the exec stage behind a valid/ready handshake, so wide (e.g. 64/128-bit) arithmetic does not need a full-width combinational carry chain.

Parameters:
W_OPR, 64, operand/result width; must be an integer multiple of W_SEG.
W_SEG, 16, slice width processed per cycle; W_SEG == W_OPR is legal (single slice).
W_FLAGS, 4, flag vector width; fixed layout {V,S,Z,C}, bit 0 = C.
(derived) NSEG = W_OPR/W_SEG; W_CNT = max(1, clog2(NSEG)).

Ports:
clk_i  input  1  clock, rising edge.
rst_n_i  input  1  asynchronous active-low reset.
valid_i  input  1  request valid.
ready_o  output  1  unit can accept a request.
opr0_i  input  W_OPR  operand A.
opr1_i  input  W_OPR  operand B.
select_i  input  2  op: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
flags_i  input  W_FLAGS  incoming flags; only bit 0 (C) is used.
flush_i  input  1  synchronous abort; drops any in-flight or held result.
valid_o  output  1  result/flags valid.
ready_i  input  1  consumer accepts the result.
result_o  output  W_OPR  sum/difference.
flags_o  output  W_FLAGS  {overflow, sign, zero, carry}.

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE, slice counter 0, carry register 0, result_o 0, flags_o 0, valid_o 0. ready_o follows state, so it is 1 in IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready_o = 1.
  - On valid_i & ready_o at a clock edge: capture opr0_i, the pre-inverted operand B (~opr1_i when select_i[0], else opr1_i), select_i[0], and the original opr1_i MSB.
  - Carry register <= select_i[0] ^ (flags_i[0] & select_i[1]). Counter <= 0. Go to BUSY.
  - flags_i is sampled only at acceptance.
- BUSY (ready_o = 0, valid_o = 0):
  - Each cycle, slice k = counter computes {c, s} = A[k] + B'[k] + carry register.
  - Write s into result slice k. Carry register <= c. Zero accumulator <= zacc & (s == 0); zacc is seeded to 1 at acceptance.
  - When counter == NSEG-1: go to DONE and set the flags:
    - C = final c.
    - Z = accumulated zero.
    - S = result MSB.
    - V = ~(A_msb ^ opr1_msb ^ sel0) & (A_msb ^ S).
  - Otherwise counter + 1.
- DONE:
  - valid_o = 1. result_o and flags_o are held stable while ready_i is 0 (unlimited backpressure).
  - On ready_i: go to IDLE and drop valid_o.
  - No new request is accepted in the DONE handshake cycle; ready_o rises the following cycle.
- Latency: a request accepted at edge k gives valid_o high after edge k+NSEG. Throughput is one op per NSEG+2 cycles with ready_i tied high.
- result_o and flags_o change only while BUSY (partial values are visible) and are defined only when valid_o = 1. They are not cleared on return to IDLE.
- flush_i:
  - Takes priority over all other transitions: go to IDLE, valid_o <= 0, and any valid_i in the same cycle is ignored.
  - flush_i in IDLE has no effect.
- Arithmetic wraps modulo 2^W_OPR. Carry-in semantics match the single-cycle exec adder exactly, including SBB with C=1 subtracting an extra 1.
- Asynchronous reset mid-BUSY or in DONE aborts immediately with no output pulse.
- Elaboration error if W_OPR % W_SEG != 0.

Test Plan:
(all with W_OPR=64, W_SEG=16, ready_i=1 unless stated)
1. ADD 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> result 0, flags 4'b0011. valid_o asserts exactly 4 cycles after acceptance; ready_o is low for BUSY+DONE.
2. SUB 0x8000_0000_0000_0000 - 0x1 -> 0x7FFF_FFFF_FFFF_FFFF, flags 4'b1001 (V=1, C=1). Also SUB 5 - 5 -> 0, flags 4'b0011.
3. ADC 5 + 7 with flags_i=4'b0001 -> 13, flags 4'b0000. Then SBB 5 - 3 with flags_i=4'b0001 -> 1, flags 4'b0001. Then SBB 5 - 3 with flags_i=0 -> 2, flags 4'b0001.
4. Cross-slice carry: ADD 0x0000_0000_0000_FFFF + 0x1 -> 0x0000_0000_0001_0000, Z=0. Also ADD 0x0001_0000_0000_0000 + 0xFFFF_0000_0000_0000 -> 0, flags 4'b0011 (Z accumulated over all slices).
5. Backpressure: hold ready_i=0 for 5 cycles in DONE -> valid_o, result_o and flags_o stay stable and ready_o stays 0. After ready_i=1 there is one cycle of DONE exit, then ready_o=1. A valid_i held during DONE is not accepted early.
6. Abort:
   - flush_i during BUSY slice 2 -> IDLE next cycle, no valid_o pulse, and the next op gives a correct result.
   - rst_n_i low mid-BUSY -> outputs 0 asynchronously; after release ready_o=1.
   - Repeat scenario 1 with W_SEG=64 (NSEG=1) -> valid_o one cycle after acceptance.
